// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared encodings for the MIPS multiply/divide unit:
//               HI/LO operation codes, controller state encoding and the
//               architectural data width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int DATA_W = 32;

  // Operation select, sampled together with start.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative multiply/divide unit with architectural HI/LO.
//               One result bit per cycle; 33-cycle latency from start to
//               done. Signed operations run on magnitudes and are corrected
//               in the FINISH cycle.
// Ports       : clk, rst_n          - clock, async active-low reset
//               start, op           - launch request and operation select
//               rs_data, rt_data    - operand A / operand B
//               hi_we, lo_we, wdata - MTHI / MTLO write port (IDLE only)
//               busy, done          - in-flight flag, one-cycle completion
//               hi, lo              - HI / LO register outputs
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(ITER + 1);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_e             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               is_div_q,  is_div_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  // Multiplicand (multiply) or divisor (divide) magnitude.
  logic [WIDTH-1:0]   opnd_q,    opnd_d;
  // Shared shift register. Multiply: {partial product, multiplier}.
  // Divide: {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [WIDTH-1:0]   hi_q,      hi_d;
  logic [WIDTH-1:0]   lo_q,      lo_d;
  logic               done_q,    done_d;

  // Operand capture
  logic             w_signed, w_is_div, w_sa, w_sb, w_div0;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;

  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign w_sa     = w_signed & rs_data[WIDTH-1];
  assign w_sb     = w_signed & rt_data[WIDTH-1];
  assign w_mag_a  = w_sa ? neg_w(rs_data) : rs_data;
  assign w_mag_b  = w_sb ? neg_w(rt_data) : rt_data;
  assign w_div0   = w_is_div && (rt_data == '0);

  // Multiply step: add multiplicand when LSB of multiplier is set, then
  // shift the whole accumulator right by one (carry kept in the sum MSB).
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step on a 33-bit shifted remainder. An unsigned
  // compare is used so that divide-by-zero (divisor 0) simply shifts the
  // dividend into the remainder while producing all-ones quotient bits.
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH-1:0]   w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, opnd_q});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - opnd_q;
  assign w_div_next  = {(w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], w_div_ge};

  // Sign-corrected results
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;

  assign w_prod = neg_quo_q ? neg_2w(acc_q) : acc_q;
  assign w_quo  = neg_quo_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign w_rem  = neg_rem_q ? neg_w(acc_q[2*WIDTH-1:WIDTH])
                            : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          is_div_d = w_is_div;
          if (w_is_div) begin
            opnd_d = w_mag_b;
            // Divide-by-zero keeps the raw dividend so it emerges as HI
            // without any sign correction.
            acc_d     = {{WIDTH{1'b0}}, (w_div0 ? rs_data : w_mag_a)};
            neg_quo_d = ~w_div0 & (w_sa ^ w_sb);
            neg_rem_d = ~w_div0 & w_sa;
          end else begin
            opnd_d    = w_mag_a;
            acc_d     = {{WIDTH{1'b0}}, w_mag_b};
            neg_quo_d = w_sa ^ w_sb;
            neg_rem_d = 1'b0;
          end
        end
      end

      S_CALC: begin
        acc_d = is_div_q ? w_div_next : w_mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FINISH;
      end

      S_FINISH: begin
        if (is_div_q) begin
          hi_d = w_rem;
          lo_d = w_quo;
        end else begin
          hi_d = w_prod[2*WIDTH-1:WIDTH];
          lo_d = w_prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS core, with architectural HI/LO registers.
- Sits directly downstream of the register file and consumes its two read ports (rs/rt data) for MULT, MULTU, DIV and DIVU.
- Holds HI/LO for MFHI/MFLO and accepts MTHI/MTLO writes.
- Control stalls the pipeline on busy.

Parameters:
- WIDTH, 32, operand/HI/LO width. Only 32 is supported; the parameter exists for bench readability.
- ITER, WIDTH, number of iteration cycles (one result bit per cycle).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  launch an operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- rs_data  input  WIDTH  operand A (multiplicand/dividend), from register file ReadData1.
- rt_data  input  WIDTH  operand B (multiplier/divisor), from register file ReadData2.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO data (rs value).
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- hi  output  WIDTH  HI register (remainder / upper product).
- lo  output  WIDTH  LO register (quotient / lower product).

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0. Iteration counter and internal accumulators are cleared.
- States: IDLE, CALC, FINISH.
- IDLE: start=1 at edge N latches the operands and op, then goes to CALC with count=0. busy=1 from edge N.
- Operand capture (signed ops): latch |A| and |B|. Record neg_q = signA^signB and neg_r = signA. For unsigned ops, both flags are 0.
- CALC: one iteration per edge, on edges N+1 to N+32. After the iteration with count=ITER-1, go to FINISH.
  - Multiply: shift-add, 64-bit accumulator.
  - Divide: restoring shift-subtract on a 33-bit partial remainder.
- FINISH, edge N+33:
  - Apply sign correction (two's-complement negate). Multiply: negate the 64-bit product if neg_q. Divide: negate the quotient if neg_q, negate the remainder if neg_r.
  - Write hi/lo, set done=1 and busy=0, return to IDLE.
  - Total latency: result visible 33 cycles after the start edge.
- done is high for exactly one cycle. It is cleared at the next edge unconditionally.
- Result mapping: multiply gives hi=product[63:32], lo=product[31:0]. Divide gives lo=quotient, hi=remainder.
- Divide by zero (DIV or DIVU): full latency still taken, no sign correction. lo=32'hFFFFFFFF, hi=rs_data as captured.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out naturally from the magnitude datapath.
- start while busy (CALC/FINISH): ignored. No queueing, operands not re-latched.
- hi_we/lo_we in IDLE: hi/lo updated at the edge, independently of each other.
- hi_we/lo_we while busy: ignored. Control must stall MTHI/MTLO behind busy.
- start and hi_we/lo_we in the same IDLE cycle: both accepted. The MT write lands first and is overwritten at FINISH.
- rst_n asserted mid-operation: immediate abort to the reset values. No done pulse is produced.
- hi/lo are pure register outputs: no combinational path from the inputs.

Decomposition:
- Shared package mips_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state encoding: S_IDLE, S_CALC, S_FINISH.
  - constant DATA_W=32.
- No sub-module. Single module with a local two's-complement negate function. The datapath stays inline because multiply and divide share the shift register and counter.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF: busy high for 33 cycles, done pulse on cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 x 5: hi=0xFFFFFFFF, lo=0xFFFFFFF1. Back-to-back start in the cycle after done is accepted.
- DIV -7 / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 2: lo=3, hi=1.
- DIVU 100 / 0: lo=0xFFFFFFFF, hi=0x00000064. DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Busy-time protection: start (new operands) and hi_we (wdata=0x1234) pulsed mid-CALC are ignored, and the original result is delivered. In IDLE, lo_we with wdata=0xABCD gives lo=0xABCD and hi unchanged.
- Reset abort: rst_n low at cycle 10 of a MULT gives busy=0, done=0, hi=lo=0 immediately. After release, no done pulse appears and a new op completes normally.
